// File: rtl/riscv_pkg.sv
// Shared RV64 core definitions: opcode constants, fetch FSM states and default widths.
package riscv_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction memory req/gnt/rvalid, decode valid/ready, branch redirect.
interface instr_fetch_if #(
    parameter int PC_W    = riscv_pkg::PC_W,
    parameter int INSTR_W = riscv_pkg::INSTR_W
) ();

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [6:0]         out_opcode;
    logic [PC_W-1:0]    out_pc;

    logic               br_valid;
    logic               br_taken;
    logic [PC_W-1:0]    br_pc;
    logic [63:0]        br_imm;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_opcode, out_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, out_ready, br_valid, br_taken, br_pc, br_imm
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_opcode, out_pc,
        output imem_gnt, imem_rvalid, imem_rdata, out_ready, br_valid, br_taken, br_pc, br_imm
    );

endinterface

// File: rtl/branch_target_add.sv
// Branch target adder: pc + (B-type immediate in halfwords << 1), wrapping modulo 2^PC_W.
module branch_target_add #(
    parameter int PC_W = riscv_pkg::PC_W
) (
    input  logic [PC_W-1:0] br_pc_i,
    input  logic [63:0]     br_imm_i,
    output logic [PC_W-1:0] target_o
);

    logic [63:0] imm_x2_s;

    // Convert halfword offset to a byte offset and add.
    always_comb begin
        imm_x2_s = br_imm_i << 1;
        target_o = br_pc_i + imm_x2_s[PC_W-1:0];
    end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage with one-entry output buffer and branch redirect.
// Optional misaligned-target trap is enabled by defining IFETCH_MISALIGN_TRAP_EN.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int              PC_W     = riscv_pkg::PC_W,
    parameter int              INSTR_W  = riscv_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_if.master       bus
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic                misalign_err
`endif
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               drop_q, drop_d;
    logic               req_q, req_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [PC_W-1:0]    out_pc_q, out_pc_d;
    logic [PC_W-1:0]    target_s;
    logic               redir_s;
    logic               err_q, err_d;
    logic               bad_target_s;

    branch_target_add #(.PC_W(PC_W)) u_bta (
        .br_pc_i  (bus.br_pc),
        .br_imm_i (bus.br_imm),
        .target_o (target_s)
    );

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign bad_target_s = bus.br_valid & bus.br_taken & (target_s[1:0] != 2'b00);
`else
    assign bad_target_s = 1'b0;
`endif
    assign redir_s = bus.br_valid & bus.br_taken & ~bad_target_s;

    // Next-state, PC and output-buffer update.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        err_d       = err_q;
        case (state_q)
            S_REQ: begin
                if (redir_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                // gnt only counts while a request is actually presented
                if (req_q && bus.imem_gnt) begin
                    state_d = S_WAIT;
                    drop_d  = redir_s;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (redir_s) begin
                    pc_d   = target_s;
                    drop_d = 1'b1;
                end else begin
                    pc_d   = pc_q;
                end
                if (bus.imem_rvalid) begin
                    if (drop_q || redir_s) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        out_instr_d = bus.imem_rdata;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_OUT: begin
                if (redir_s) begin
                    pc_d        = target_s;
                    out_valid_d = 1'b0;
                    state_d     = S_REQ;
                end else if (out_valid_q && bus.out_ready) begin
                    pc_d        = pc_q + {{(PC_W-3){1'b0}}, 3'd4};
                    out_valid_d = 1'b0;
                    state_d     = S_REQ;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
        // A trapped fetch freezes; a new misaligned redirect parks it in S_OUT with nothing valid.
        if (err_q) begin
            state_d     = state_q;
            pc_d        = pc_q;
            drop_d      = drop_q;
            out_valid_d = out_valid_q;
        end else if (bad_target_s) begin
            pc_d        = pc_q;
            err_d       = 1'b1;
            out_valid_d = 1'b0;
            state_d     = S_OUT;
        end else begin
            err_d = err_q;
        end
        req_d = (state_d == S_REQ);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            req_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= {INSTR_W{1'b0}};
            out_pc_q    <= {PC_W{1'b0}};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            req_q       <= req_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    // Sticky misaligned-target flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign misalign_err = err_q;
`else
    assign err_q = 1'b0;
`endif

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = pc_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_instr  = out_instr_q;
    assign bus.out_opcode = out_instr_q[6:0];
    assign bus.out_pc     = out_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, stall, redirects, reset mid-flight, misalign.
module tb_instr_fetch;

    logic clk;
    logic rst_n;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic misalign_err;
`endif

    int   checks;
    int   errors;
    bit   fire;
    bit   rsp_en;
    logic [63:0] faddr;
    logic [31:0] exp_instr;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(64'h1000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef IFETCH_MISALIGN_TRAP_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; memory answers one cycle after a grant when rsp_en is set.
    task automatic tick();
        fire  = bus.imem_req && bus.imem_gnt;
        faddr = bus.imem_addr;
        @(posedge clk);
        #1;
        bus.imem_rvalid = rsp_en && fire;
        bus.imem_rdata  = instr_of(faddr);
        bus.br_valid    = 1'b0;
        bus.br_taken    = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rsp_en = 1'b1;
        rst_n  = 1'b1;
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.out_ready   = 1'b1;
        bus.br_valid    = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_pc       = 64'h0;
        bus.br_imm      = 64'h0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req",       {63'h0, bus.imem_req},  64'h0);
        chk("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("rst_out_instr", {32'h0, bus.out_instr}, 64'h0);
        chk("rst_out_pc",    bus.out_pc,             64'h0);
        chk("rst_addr",      bus.imem_addr,          64'h1000);
        #1 rst_n = 1'b1;

        // Sequential fetch 0x1000, 0x1004, 0x1008 with 3-cycle spacing
        tick();
        chk("first_req",  {63'h0, bus.imem_req}, 64'h1);
        chk("first_addr", bus.imem_addr,         64'h1000);
        tick();
        chk("wait_req",   {63'h0, bus.imem_req},  64'h0);
        chk("wait_ov",    {63'h0, bus.out_valid}, 64'h0);
        tick();
        exp_instr = instr_of(64'h1000);
        chk("ov0",     {63'h0, bus.out_valid},  64'h1);
        chk("pc0",     bus.out_pc,              64'h1000);
        chk("instr0",  {32'h0, bus.out_instr},  {32'h0, exp_instr});
        chk("opcode0", {57'h0, bus.out_opcode}, {57'h0, exp_instr[6:0]});
        tick();
        chk("ov_gap1", {63'h0, bus.out_valid}, 64'h0);
        chk("addr1",   bus.imem_addr,          64'h1004);
        tick();
        chk("ov_gap2", {63'h0, bus.out_valid}, 64'h0);
        tick();
        chk("ov1", {63'h0, bus.out_valid}, 64'h1);
        chk("pc1", bus.out_pc,             64'h1004);
        tick();
        tick();
        tick();
        chk("ov2", {63'h0, bus.out_valid}, 64'h1);
        chk("pc2", bus.out_pc,             64'h1008);

        // Back-pressure: five stalled cycles
        bus.out_ready = 1'b0;
        exp_instr = instr_of(64'h1008);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ov",    {63'h0, bus.out_valid}, 64'h1);
            chk("stall_pc",    bus.out_pc,             64'h1008);
            chk("stall_instr", {32'h0, bus.out_instr}, {32'h0, exp_instr});
            chk("stall_req",   {63'h0, bus.imem_req},  64'h0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("release_req",  {63'h0, bus.imem_req}, 64'h1);
        chk("release_addr", bus.imem_addr,         64'h100C);

        // Redirect while waiting for the response
        rsp_en = 1'b0;
        tick();
        bus.br_valid = 1'b1;
        bus.br_taken = 1'b1;
        bus.br_pc    = 64'h2000;
        bus.br_imm   = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        chk("wredir_req", {63'h0, bus.imem_req},  64'h0);
        chk("wredir_ov",  {63'h0, bus.out_valid}, 64'h0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        chk("wdrop_ov",   {63'h0, bus.out_valid}, 64'h0);
        chk("wdrop_req",  {63'h0, bus.imem_req},  64'h1);
        chk("wdrop_addr", bus.imem_addr,          64'h1FF8);
        rsp_en = 1'b1;

        // Redirect coinciding with grant
        bus.br_valid = 1'b1;
        bus.br_taken = 1'b1;
        bus.br_pc    = 64'h3000;
        bus.br_imm   = 64'h10;
        tick();
        chk("gredir_req", {63'h0, bus.imem_req}, 64'h0);
        tick();
        chk("gdrop_ov",   {63'h0, bus.out_valid}, 64'h0);
        chk("gdrop_addr", bus.imem_addr,          64'h3020);
        tick();
        tick();
        chk("gtgt_ov",    {63'h0, bus.out_valid}, 64'h1);
        chk("gtgt_pc",    bus.out_pc,             64'h3020);
        chk("gtgt_instr", {32'h0, bus.out_instr}, {32'h0, instr_of(64'h3020)});

        // Redirect in S_OUT without a handshake
        bus.out_ready = 1'b0;
        bus.br_valid  = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_pc     = 64'h400;
        bus.br_imm    = 64'h2;
        tick();
        chk("oredir_ov",   {63'h0, bus.out_valid}, 64'h0);
        chk("oredir_addr", bus.imem_addr,          64'h404);
        // Not-taken branch must be ignored
        bus.out_ready = 1'b1;
        bus.br_valid  = 1'b1;
        bus.br_taken  = 1'b0;
        bus.br_pc     = 64'h9000;
        bus.br_imm    = 64'h0;
        tick();
        tick();
        chk("nt_pc", bus.out_pc, 64'h404);
        tick();
        chk("nt_next_addr", bus.imem_addr, 64'h408);

        // Reset pulse during S_WAIT, stale response after release
        rsp_en = 1'b0;
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_ov",   {63'h0, bus.out_valid}, 64'h0);
        chk("mrst_addr", bus.imem_addr,          64'h1000);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_BAD0;
        #1 rst_n = 1'b1;
        tick();
        chk("mrst_stale_ov", {63'h0, bus.out_valid}, 64'h0);
        chk("mrst_req",      {63'h0, bus.imem_req},  64'h1);
        chk("mrst_req_addr", bus.imem_addr,          64'h1000);
        rsp_en = 1'b1;
        tick();
        tick();
        chk("mrst_out_pc", bus.out_pc, 64'h1000);

        // Misaligned redirect target 0x102
        bus.out_ready = 1'b0;
        bus.br_valid  = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_pc     = 64'h100;
        bus.br_imm    = 64'h1;
        tick();
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("mis_err", {63'h0, misalign_err},   64'h1);
        chk("mis_ov",  {63'h0, bus.out_valid},  64'h0);
        tick();
        chk("mis_halt_req",  {63'h0, bus.imem_req}, 64'h0);
        chk("mis_halt_addr", bus.imem_addr,         64'h1000);
        chk("mis_err_hold",  {63'h0, misalign_err}, 64'h1);
`else
        chk("mis_req",  {63'h0, bus.imem_req},  64'h1);
        chk("mis_addr", bus.imem_addr,          64'h102);
        chk("mis_ov",   {63'h0, bus.out_valid}, 64'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the sign-extend/decode logic in the single-cycle-class RISC-V (RV64) core.
- Holds the 64-bit PC, issues word requests to instruction memory over a req/gnt + rvalid handshake, and buffers one instruction.
- Presents the instruction and its 7-bit opcode to decode through a valid/ready handshake.
- Accepts branch redirects whose offset is the 64-bit sign-extended B-type immediate (imm[12:1] encoding); the target is computed here.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- PC_W, 64, PC / address width.
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  single core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  PC_W  byte address of the request (current PC).
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  response data valid; exactly one per granted request, at least 1 cycle after gnt.
- imem_rdata  in  INSTR_W  response instruction word.
- out_valid  out  1  buffered instruction valid to decode.
- out_ready  in  1  decode accepts the instruction.
- out_instr  out  INSTR_W  buffered instruction.
- out_opcode  out  7  out_instr[6:0].
- out_pc  out  PC_W  PC of out_instr.
- br_valid  in  1  redirect request from execute.
- br_taken  in  1  branch condition true; ignored unless br_valid.
- br_pc  in  PC_W  PC of the branch instruction.
- br_imm  in  64  sign-extended immediate, in halfword units.

Behaviour:
- Reset: async assert when rst_n=0. pc=RESET_PC, state=S_REQ, drop=0, out_valid=0, imem_req=0, out_instr=0, out_pc=0. imem_req first asserts on the first clk edge after rst_n deasserts.
- Redirect event (redir) = br_valid & br_taken.
- Redirect target = br_pc + (br_imm << 1), modulo 2^64; no overflow detection.
- S_REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt: go to S_WAIT.
  - On redir: pc=target.
  - On redir and gnt in the same cycle: go to S_WAIT with drop=1.
- S_WAIT:
  - imem_req=0.
  - On redir: pc=target, drop=1.
  - On imem_rvalid with drop=1 (including drop being set in the same cycle): discard the data, drop=0, go to S_REQ.
  - On imem_rvalid with drop=0: out_instr=rdata, out_pc=pc, out_valid=1, go to S_OUT.
- S_OUT:
  - out_valid=1; out_instr, out_opcode and out_pc are stable until the handshake completes.
  - On out_valid & out_ready without redir: pc=pc+4, out_valid=0, go to S_REQ.
  - On redir (with or without out_ready): pc=target, out_valid=0, go to S_REQ. A same-cycle handshake still counts as consumed.
- Latency: minimum 3 cycles from request to out_valid (gnt same cycle, rvalid next cycle). Steady-state throughput is 1 instruction per 3 cycles. No prefetch, at most 1 outstanding request.
- imem_rvalid seen in S_REQ or S_OUT is a protocol error; it is ignored.
- br_valid with br_taken=0: no effect.

Optional Feature:
- Macro: IFETCH_MISALIGN_TRAP_EN.
- Defined:
  - Extra output misalign_err (1 bit), reset 0.
  - On redir with target[1:0]!=0: pc is not updated, misalign_err=1 is sticky until reset, state=S_OUT with out_valid forced 0. The fetch halts.
- Undefined:
  - Target is used as-is; bits [1:0] are forwarded to imem_addr unchanged.
  - No misalign_err port.

Decomposition:
- Shared package riscv_pkg holds:
  - Opcode constants OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011.
  - Fetch state enum {S_REQ, S_WAIT, S_OUT}.
  - PC_W and INSTR_W defaults.
- One natural sub-module: branch_target_add, purely combinational, (br_pc, br_imm) -> target. It is shared later by the JAL path.

Test Plan:
- Reset with RESET_PC=64'h1000, memory gnt immediate, rvalid 1 cycle later, out_ready=1 -> out_pc sequence 0x1000, 0x1004, 0x1008, with out_valid pulses 3 cycles apart.
- out_ready held low 5 cycles in S_OUT -> out_instr/out_pc stable, imem_req=0 throughout; on release pc advances by exactly 4.
- Redirect in S_WAIT: br_pc=0x2000, br_imm=64'hFFFF_FFFF_FFFF_FFFC (-4) -> the in-flight response is dropped (out_valid stays 0) and the next imem_addr is 0x1FF8.
- Redirect and imem_gnt in the same cycle in S_REQ -> that response is discarded; the next request goes to the target address.
- rst_n pulsed low mid-S_WAIT with rvalid arriving after release -> out_valid=0, imem_addr=RESET_PC.
- With IFETCH_MISALIGN_TRAP_EN defined, br_imm=1 from br_pc=0x100 (target 0x102) -> misalign_err=1, fetch halts; without the macro, the next imem_addr is 0x102.
